// File: rtl/contador_mod10_if.sv
// ---------------------------------------------------------------------------
// contador_mod10_if
// Signal bundle for the single-digit BCD down-counter contador_mod10.
//
// Signals:
//   loadn  synchronous parallel load, active-low (controller -> counter)
//   data   BCD value to load                     (controller -> counter)
//   en     count enable, active-high             (controller -> counter)
//   tc     terminal count / borrow to next digit (counter -> controller)
//   zero   high while the digit is 0             (counter -> controller)
//   ones   current BCD digit                     (counter -> controller)
//
// Modports:
//   master  the controller side that drives load/enable
//   slave   the counter side
// ---------------------------------------------------------------------------
interface contador_mod10_if;
    logic       loadn;
    logic [3:0] data;
    logic       en;
    logic       tc;
    logic       zero;
    logic [3:0] ones;

    modport master (
        output loadn,
        output data,
        output en,
        input  tc,
        input  zero,
        input  ones
    );

    modport slave (
        input  loadn,
        input  data,
        input  en,
        output tc,
        output zero,
        output ones
    );
endinterface

// File: rtl/contador_mod10.sv
// ---------------------------------------------------------------------------
// contador_mod10
// Single-digit BCD down-counter (modulo 10), used as the "ones" digit of the
// countdown timer. Supports synchronous parallel load, count enable and an
// asynchronous clear. A combinational borrow (tc) lets a cascaded higher
// digit decrement on the same edge that wraps this digit from 0 to 9.
//
// Parameters:
//   RESET_VALUE  value of ones while/after clear; must be 0..9
//
// Ports:
//   clk    system clock, rising-edge active
//   clear  asynchronous active-high clear, forces ones to RESET_VALUE
//   bus    contador_mod10_if.slave:
//            loadn/data  synchronous load (load wins over count)
//            en          count enable
//            tc          en & loadn & (ones == 0)
//            zero        ones == 0
//            ones        registered BCD digit
//
// Build option:
//   CONTADOR_MOD10_CLAMP_EN  defined   -> a load of 10..15 stores 9
//                            undefined -> a load of 10..15 is ignored
// ---------------------------------------------------------------------------
module contador_mod10 #(
    parameter logic [3:0] RESET_VALUE = 4'd0
) (
    input  logic             clk,
    input  logic             clear,
    contador_mod10_if.slave  bus
);

    localparam logic [3:0] DIGIT_MAX = 4'd9;

    generate
        if (RESET_VALUE > DIGIT_MAX) begin : g_bad_reset_value
            $error("contador_mod10: RESET_VALUE must be in 0..9");
        end
    endgenerate

    logic [3:0] ones_q;
    logic [3:0] ones_d;
    logic       is_zero;
    logic       data_valid;

    assign is_zero    = (ones_q == 4'd0);
    assign data_valid = (bus.data <= DIGIT_MAX);

    // Load beats count beats hold. Out-of-range load data never reaches the
    // register, so ones stays within 0..9 in every mode.
    always_comb begin
        ones_d = ones_q;
        if (!bus.loadn) begin
            if (data_valid) begin
                ones_d = bus.data;
            end else begin
`ifdef CONTADOR_MOD10_CLAMP_EN
                ones_d = DIGIT_MAX;
`else
                ones_d = ones_q;
`endif
            end
        end else if (bus.en) begin
            ones_d = is_zero ? DIGIT_MAX : (ones_q - 4'd1);
        end
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            ones_q <= RESET_VALUE;
        end else begin
            ones_q <= ones_d;
        end
    end

    assign bus.ones = ones_q;
    assign bus.zero = is_zero;
    // Borrow is suppressed during a load so a higher digit does not decrement
    // when this digit is being overwritten.
    assign bus.tc   = bus.en & bus.loadn & is_zero;

endmodule

// File: tb/tb_contador_mod10.sv
// ---------------------------------------------------------------------------
// tb_contador_mod10
// Directed self-checking bench for contador_mod10 (default RESET_VALUE).
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_contador_mod10;

    logic clk;
    logic clear;

    int checks;
    int errors;

    contador_mod10_if bus ();

    contador_mod10 #(
        .RESET_VALUE (4'd0)
    ) dut (
        .clk   (clk),
        .clear (clear),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [3:0] exp_ones,
                             input logic exp_zero, input logic exp_tc);
        check({tag, ".ones"}, bus.ones, exp_ones);
        check({tag, ".zero"}, {3'b000, bus.zero}, {3'b000, exp_zero});
        check({tag, ".tc"},   {3'b000, bus.tc},   {3'b000, exp_tc});
    endtask

    task automatic load(input logic [3:0] value);
        bus.loadn = 1'b0;
        bus.en    = 1'b0;
        bus.data  = value;
        step();
        bus.loadn = 1'b1;
    endtask

    logic [3:0] count_seq [8];
    logic [3:0] exp_invalid;

    initial begin
        checks = 0;
        errors = 0;
        count_seq = '{4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0, 4'd9, 4'd8};
`ifdef CONTADOR_MOD10_CLAMP_EN
        exp_invalid = 4'd9;
`else
        exp_invalid = 4'd5;
`endif

        // Reset with clock idle (first edge at t=5).
        clear     = 1'b1;
        bus.loadn = 1'b1;
        bus.en    = 1'b0;
        bus.data  = 4'd0;
        #3;
        check_all("reset_idle", 4'd0, 1'b1, 1'b0);
        bus.en = 1'b1;
        #1;
        check_all("reset_en", 4'd0, 1'b1, 1'b1);
        step();
        step();
        check_all("reset_en_edges", 4'd0, 1'b1, 1'b1);

        // Load 6, then hold for 3 edges.
        clear     = 1'b0;
        bus.en    = 1'b0;
        bus.loadn = 1'b0;
        bus.data  = 4'd6;
        step();
        check_all("load6", 4'd6, 1'b0, 1'b0);
        bus.loadn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_all("hold6", 4'd6, 1'b0, 1'b0);
        end

        // Count down through the wrap.
        bus.en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            check_all($sformatf("count%0d", i), count_seq[i],
                      count_seq[i] == 4'd0, count_seq[i] == 4'd0);
        end

        // Load has priority over count.
        load(4'd3);
        check_all("load3", 4'd3, 1'b0, 1'b0);
        bus.loadn = 1'b0;
        bus.data  = 4'd7;
        bus.en    = 1'b1;
        step();
        check_all("load_prio", 4'd7, 1'b0, 1'b0);

        // At ones=0, load with en=1 suppresses tc and beats the wrap.
        load(4'd0);
        bus.loadn = 1'b0;
        bus.data  = 4'd7;
        bus.en    = 1'b1;
        #1;
        check_all("load_at_zero_tc", 4'd0, 1'b1, 1'b0);
        step();
        check_all("load_at_zero_edge", 4'd7, 1'b0, 1'b0);
        bus.loadn = 1'b1;

        // Asynchronous clear between edges while counting.
        load(4'd4);
        bus.en = 1'b1;
        #2;
        clear = 1'b1;
        #1;
        check_all("async_clear", 4'd0, 1'b1, 1'b1);
        clear = 1'b0;
        step();
        check_all("after_clear", 4'd9, 1'b0, 1'b0);
        bus.en = 1'b0;

        // Out-of-range and boundary loads.
        load(4'd5);
        check_all("load5", 4'd5, 1'b0, 1'b0);
        load(4'd12);
        check_all("load12", exp_invalid, 1'b0, 1'b0);
        load(4'd5);
        load(4'd15);
        check_all("load15", exp_invalid, 1'b0, 1'b0);
        load(4'd0);
        check_all("load0", 4'd0, 1'b1, 1'b0);
        load(4'd9);
        check_all("load9", 4'd9, 1'b0, 1'b0);
        load(4'd10);
        check_all("load10_from9", 4'd9, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
